// File: rtl/sprite_loader_pkg.sv
// Shared definitions for the sprite loader: default geometry, the
// transparent colour, FSM state encoding and the pixel-packing helper.
package sprite_loader_pkg;

  localparam int          ROW_W_DEF       = 5;
  localparam int          COL_W_DEF       = 5;
  localparam int          PIX_W           = 12;
  localparam logic [11:0] TRANSPARENT_DEF = 12'hFFF;

  // Loader states. CHK is only reachable when the checksum option is built in.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    CHK  = 3'd3,
    FULL = 3'd4
  } state_t;

  // byte0 = {R,G}, byte1 = {B, don't care}; the pixel is {R,G,B}.
  function automatic logic [PIX_W-1:0] pack_pixel(input logic [7:0] rg_byte,
                                                  input logic [7:0] b_byte);
    return {rg_byte, b_byte[7:4]};
  endfunction

endpackage

// File: rtl/sprite_loader_dpram.sv
// Simple dual-port sprite RAM: one synchronous write port, one read port
// with a registered output. No reset on the array or the read register so
// the structure maps onto a block RAM.
module sprite_dpram
  import sprite_loader_pkg::*;
#(
  parameter int AW = 11,
  parameter int DW = PIX_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  // Write port: one pixel per cycle when we is high.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: address sampled on the edge, data valid one clock later.
  always_ff @(posedge clk) begin
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sprite_loader.sv
// Sprite loader top: accepts a valid/ready byte stream of 12-bit pixels,
// writes each image into the back bank of a double-buffered sprite RAM and
// flips the display bank on the first vblank rising edge after the image is
// complete. The display side reads {front,row,col} with 1-clock latency.
//
// Build option: define SPRITE_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte after the last pixel (state CHK). Without it, the last pixel
// goes straight to FULL and no checksum logic exists.
//
// Stream handshake: a byte moves when s_valid && s_ready are both high on a
// rising clock edge; s_sof and s_data are only meaningful while s_valid is
// high, and s_ready does not depend on s_valid.
module sprite_loader
  import sprite_loader_pkg::*;
#(
  parameter int          W           = 30,
  parameter int          H           = 30,
  parameter int          ROW_W       = ROW_W_DEF,
  parameter int          COL_W       = COL_W_DEF,
  parameter logic [11:0] TRANSPARENT = TRANSPARENT_DEF
) (
  input  logic             ClkPort,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_sof,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  input  logic             vblank,
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  output logic [11:0]      color_data,
  output logic             loading,
  output logic             swap_done,
  output logic             err,
  output state_t           dbg_state
);

  localparam int AW = 1 + ROW_W + COL_W;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(H - 1);
  localparam logic [COL_W:0]   W_LIM    = (COL_W + 1)'(W);
  localparam logic [ROW_W:0]   H_LIM    = (ROW_W + 1)'(H);

  state_t           state_q, state_d;
  logic             front_q, front_d;
  logic [ROW_W-1:0] row_w_q, row_w_d;
  logic [COL_W-1:0] col_w_q, col_w_d;
  logic [7:0]       rg_q, rg_d;
  logic             s_ready_q, s_ready_d;
  logic             swap_done_q, swap_done_d;
  logic             err_q, err_d;
  logic             vblank_q, vblank_d;
  logic             oob_q, oob_d;
  logic             rd_vld_q, rd_vld_d;
`ifdef SPRITE_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic             xfer;
  logic             last_pix;
  logic             start_img;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [11:0]      wdata;
  logic [AW-1:0]    raddr;
  logic [11:0]      ram_rdata;

  // Next-state, counter, bank-select and pulse logic for the loader FSM.
  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    row_w_d     = row_w_q;
    col_w_d     = col_w_q;
    rg_d        = rg_q;
    swap_done_d = 1'b0;
    err_d       = 1'b0;
    start_img   = 1'b0;
    we          = 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    xfer     = s_valid && s_ready_q;
    last_pix = (col_w_q == COL_LAST) && (row_w_q == ROW_LAST);
    waddr    = {~front_q, row_w_q, col_w_q};
    wdata    = pack_pixel(rg_q, s_data);

    case (state_q)
      // Wait for a start-of-frame byte; anything else is discarded.
      IDLE: begin
        if (xfer && s_sof) begin
          start_img = 1'b1;
        end
      end

      // Expecting the {R,G} byte of the next pixel.
      HI: begin
        if (xfer) begin
          if (s_sof) begin
            err_d     = 1'b1;
            start_img = 1'b1;
          end else begin
            rg_d    = s_data;
            state_d = LO;
`ifdef SPRITE_LOADER_CHECKSUM_EN
            csum_d  = csum_q ^ s_data;
`endif
          end
        end
      end

      // Expecting the {B,x} byte: completes a pixel and writes it.
      LO: begin
        if (xfer) begin
          if (s_sof) begin
            err_d     = 1'b1;
            start_img = 1'b1;
          end else begin
            we = 1'b1;
`ifdef SPRITE_LOADER_CHECKSUM_EN
            csum_d = csum_q ^ s_data;
`endif
            if (last_pix) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
              state_d = CHK;
`else
              state_d = FULL;
`endif
            end else begin
              if (col_w_q == COL_LAST) begin
                col_w_d = '0;
                row_w_d = row_w_q + 1'b1;
              end else begin
                col_w_d = col_w_q + 1'b1;
              end
              state_d = HI;
            end
          end
        end
      end

`ifdef SPRITE_LOADER_CHECKSUM_EN
      // One trailing byte that must equal the XOR of every pixel byte.
      CHK: begin
        if (xfer) begin
          if (s_sof) begin
            err_d     = 1'b1;
            start_img = 1'b1;
          end else if (s_data == csum_q) begin
            state_d = FULL;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif

      // Image complete: hold off the stream until a fresh vblank rising edge.
      FULL: begin
        if (vblank && !vblank_q) begin
          front_d     = ~front_q;
          swap_done_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A start-of-frame byte always begins a fresh image from (0,0).
    if (start_img) begin
      rg_d    = s_data;
      row_w_d = '0;
      col_w_d = '0;
      state_d = LO;
`ifdef SPRITE_LOADER_CHECKSUM_EN
      csum_d  = s_data;
`endif
    end

    // Registered ready: low only while an image waits for its swap.
    s_ready_d = (state_d != FULL);
  end

  // Read-side bookkeeping: out-of-range flag travels alongside the RAM read.
  always_comb begin
    vblank_d = vblank;
    oob_d    = ({1'b0, col} >= W_LIM) || ({1'b0, row} >= H_LIM);
    rd_vld_d = 1'b1;
    raddr    = {front_q, row, col};
  end

  // State and control registers.
  always_ff @(posedge ClkPort or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      front_q     <= 1'b0;
      row_w_q     <= '0;
      col_w_q     <= '0;
      rg_q        <= '0;
      s_ready_q   <= 1'b0;
      swap_done_q <= 1'b0;
      err_q       <= 1'b0;
      vblank_q    <= 1'b0;
      oob_q       <= 1'b0;
      rd_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      row_w_q     <= row_w_d;
      col_w_q     <= col_w_d;
      rg_q        <= rg_d;
      s_ready_q   <= s_ready_d;
      swap_done_q <= swap_done_d;
      err_q       <= err_d;
      vblank_q    <= vblank_d;
      oob_q       <= oob_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

`ifdef SPRITE_LOADER_CHECKSUM_EN
  // Running XOR of the pixel bytes of the image in progress.
  always_ff @(posedge ClkPort or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  sprite_dpram #(
    .AW (AW),
    .DW (12)
  ) u_ram (
    .clk   (ClkPort),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  // Reads outside the sprite return the transparent colour; the RAM output
  // is masked to zero until the first read after reset has completed.
  assign color_data = !rd_vld_q ? 12'h000 :
                      oob_q     ? TRANSPARENT : ram_rdata;
  assign s_ready    = s_ready_q;
  assign swap_done  = swap_done_q;
  assign err        = err_q;
  assign loading    = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule
